// File: rtl/mem_if_pkg.sv
// Shared definitions for the processor data-memory interface: size codes,
// mask encodings, initiator FSM states and the LED store address.
package mem_if_pkg;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [2:0] MASK_B = 3'b001;
  localparam logic [2:0] MASK_H = 3'b011;
  localparam logic [2:0] MASK_W = 3'b111;

  localparam logic [31:0] LED_ADDR = 32'h2000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;
endpackage

// File: rtl/mem_req_encode.sv
// Combinational request decode: {sign, mask} for the memory plus a flag for
// accesses that must never reach memory (misaligned or illegal size).
module mem_req_encode
  import mem_if_pkg::*;
(
  input  logic [1:0] size,
  input  logic       zero_ext,
  input  logic       write,
  input  logic [1:0] addr_lo,
  output logic [3:0] sign_mask,
  output logic       misaligned
);
  logic [2:0] mask;

  always_comb begin
    mask       = 3'b000;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: mask = MASK_B;
      SZ_HALF: begin
        mask       = MASK_H;
        misaligned = addr_lo[0];
      end
      SZ_WORD: begin
        mask       = MASK_W;
        misaligned = |addr_lo;
      end
      default: misaligned = 1'b1;
    endcase
  end

  // stores never sign-extend; only loads honour the unsigned flag
  assign sign_mask = {~zero_ext & ~write, mask};
endmodule

// File: rtl/data_mem_initiator.sv
// Load/store initiator: one registered strobe per access, fixed read latency,
// one response per accepted request; misaligned requests bypass memory.
module data_mem_initiator
  import mem_if_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_memwrite,
  output logic              mem_memread,
  output logic [3:0]        mem_sign_mask,
  input  logic [DATA_W-1:0] mem_read_data
);
  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             accept, lat_done, is_load;
  logic [3:0]       sign_mask;
  logic             misaligned;

  mem_req_encode u_enc (
    .size       (req_size),
    .zero_ext   (req_unsigned),
    .write      (req_write),
    .addr_lo    (req_addr[1:0]),
    .sign_mask  (sign_mask),
    .misaligned (misaligned)
  );

  assign req_ready  = (state == S_IDLE) || (state == S_RESP);
  assign resp_valid = (state == S_RESP);
  assign accept     = req_valid & req_ready;
  assign lat_done   = (cnt == CNT_W'(RD_LATENCY - 1));

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_RESP: begin
        if (accept) state_nx = misaligned ? S_RESP : S_ISSUE;
        else        state_nx = S_IDLE;
      end
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (lat_done) state_nx = S_RESP;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      is_load        <= 1'b0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_memwrite   <= 1'b0;
      mem_memread    <= 1'b0;
      mem_sign_mask  <= 4'b0;
    end else begin
      state        <= state_nx;
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
      if ((state == S_WAIT) && !lat_done) cnt <= cnt + 1'b1;
      else                                cnt <= '0;
      if (accept) begin
        mem_addr       <= req_addr;
        mem_write_data <= req_wdata;
        mem_sign_mask  <= sign_mask;
        is_load        <= ~req_write;
        resp_err       <= misaligned;
        if (misaligned) begin
          resp_rdata <= '0;
        end else begin
          mem_memread  <= ~req_write;
          mem_memwrite <= req_write;
        end
      end
      // capture on the edge entering RESP; memory extended the data already
      if ((state == S_WAIT) && lat_done)
        resp_rdata <= is_load ? mem_read_data : '0;
    end
  end
endmodule

// File: tb/tb_data_mem_initiator.sv
// Directed bench for data_mem_initiator: vector table of single accesses plus
// sequences for reset abort, back-to-back requests and a 3-cycle-latency build.
module tb_data_mem_initiator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_valid3 = 1'b0;
  logic        req_write = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_ready, resp_valid, resp_err, mem_memwrite, mem_memread;
  logic [31:0] resp_rdata, mem_addr, mem_write_data, mem_read_data;
  logic [3:0]  mem_sign_mask;
  logic        req_ready3, resp_valid3, resp_err3, mem_memwrite3, mem_memread3;
  logic [31:0] resp_rdata3, mem_addr3, mem_write_data3, mem_read_data3;
  logic [3:0]  mem_sign_mask3;

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  data_mem_initiator #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_memwrite(mem_memwrite),
    .mem_memread(mem_memread), .mem_sign_mask(mem_sign_mask),
    .mem_read_data(mem_read_data));

  data_mem_initiator #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned), .resp_valid(resp_valid3),
    .resp_rdata(resp_rdata3), .resp_err(resp_err3), .mem_addr(mem_addr3),
    .mem_write_data(mem_write_data3), .mem_memwrite(mem_memwrite3),
    .mem_memread(mem_memread3), .mem_sign_mask(mem_sign_mask3),
    .mem_read_data(mem_read_data3));

  // little-endian word memory; extension done here from the DUT's sign_mask
  logic [31:0] mem [0:1023];
  logic [31:0] rd_a;
  logic [3:0]  rd_sm;
  logic        rd_pend = 1'b0;

  function automatic logic [31:0] merge(logic [31:0] old, logic [1:0] lo,
                                        logic [31:0] d, logic [2:0] m);
    logic [31:0] w = old;
    if (m == 3'b001)      w[lo*8 +: 8] = d[7:0];
    else if (m == 3'b011) w[lo[1]*16 +: 16] = d[15:0];
    else                  w = d;
    return w;
  endfunction

  function automatic logic [31:0] ext(logic [31:0] word, logic [1:0] lo, logic [3:0] sm);
    logic [31:0] v = word >> (lo * 8);
    if (sm[2:0] == 3'b001) return sm[3] ? {{24{v[7]}}, v[7:0]} : {24'b0, v[7:0]};
    if (sm[2:0] == 3'b011) return sm[3] ? {{16{v[15]}}, v[15:0]} : {16'b0, v[15:0]};
    return v;
  endfunction

  always @(posedge clk) begin
    if (mem_memwrite)
      mem[mem_addr[11:2]] <= merge(mem[mem_addr[11:2]], mem_addr[1:0],
                                   mem_write_data, mem_sign_mask[2:0]);
    if (mem_memread) begin
      rd_a    <= mem_addr;
      rd_sm   <= mem_sign_mask;
      rd_pend <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rd_pend) begin
      mem_read_data <= ext(mem[rd_a[11:2]], rd_a[1:0], rd_sm);
      rd_pend       <= 1'b0;
    end
    if (mem_memread && mem_memwrite) overlap++;
    if (mem_memread3 && mem_memwrite3) overlap++;
  end

  // latency-3 memory: good data only in the window ending at the capture edge
  int lat3 = 0;
  always @(posedge clk) begin
    if (mem_memread3)  lat3 <= 3;
    else if (lat3 != 0) lat3 <= lat3 - 1;
  end
  always @(negedge clk)
    mem_read_data3 <= (lat3 == 1) ? 32'h600DF00D : 32'hBAD0BAD0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    logic [3:0]  sm;
  } vec_t;

  vec_t vecs[13];

  task automatic drive(logic w, logic [31:0] a, logic [31:0] d, logic [1:0] s, logic u);
    req_write = w; req_addr = a; req_wdata = d; req_size = s; req_unsigned = u;
  endtask

  // lat = posedges after the accepting edge before resp_valid is visible
  task automatic run_vec(int i, vec_t v);
    int n = 0, lat = 0, strobes = 0;
    @(negedge clk);
    drive(v.write, v.addr, v.wdata, v.size, v.uns);
    req_valid = 1'b1;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    while (!resp_valid && lat < 20) begin
      strobes += int'(mem_memread) + int'(mem_memwrite);
      @(negedge clk);
      lat++;
    end
    check($sformatf("v%0d latency", i), 32'(lat), 32'(v.lat));
    check($sformatf("v%0d strobes", i), 32'(strobes), v.err ? 32'd0 : 32'd1);
    check($sformatf("v%0d err", i), {31'b0, resp_err}, {31'b0, v.err});
    check($sformatf("v%0d rdata", i), resp_rdata, v.rdata);
    if (!v.err) check($sformatf("v%0d sign_mask", i), {28'b0, mem_sign_mask}, {28'b0, v.sm});
    @(negedge clk);
    check($sformatf("v%0d resp pulse", i), {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[2] = 32'hCAFEF00D;

    //          wr    addr          wdata          sz    uns   err   rdata          lat sm
    vecs[0]  = '{1'b1, 32'h1004, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0, 32'h0,        2, 4'b0111};
    vecs[1]  = '{1'b0, 32'h1004, 32'h0,        2'd2, 1'b0, 1'b0, 32'hDEADBEEF, 2, 4'b1111};
    vecs[2]  = '{1'b1, 32'h1004, 32'h00008000, 2'd2, 1'b0, 1'b0, 32'h0,        2, 4'b0111};
    vecs[3]  = '{1'b0, 32'h1005, 32'h0,        2'd0, 1'b0, 1'b0, 32'hFFFFFF80, 2, 4'b1001};
    vecs[4]  = '{1'b0, 32'h1005, 32'h0,        2'd0, 1'b1, 1'b0, 32'h00000080, 2, 4'b0001};
    vecs[5]  = '{1'b0, 32'h1002, 32'h0,        2'd2, 1'b0, 1'b1, 32'h0,        0, 4'b0000};
    vecs[6]  = '{1'b0, 32'h1001, 32'h0,        2'd1, 1'b0, 1'b1, 32'h0,        0, 4'b0000};
    vecs[7]  = '{1'b1, 32'h1000, 32'h1,        2'd3, 1'b0, 1'b1, 32'h0,        0, 4'b0000};
    vecs[8]  = '{1'b1, 32'h1006, 32'h1234ABCD, 2'd1, 1'b0, 1'b0, 32'h0,        2, 4'b0011};
    vecs[9]  = '{1'b0, 32'h1006, 32'h0,        2'd1, 1'b0, 1'b0, 32'hFFFFABCD, 2, 4'b1011};
    vecs[10] = '{1'b1, 32'h2000, 32'h5,        2'd2, 1'b0, 1'b0, 32'h0,        2, 4'b0111};
    vecs[11] = '{1'b0, 32'h2000, 32'h0,        2'd2, 1'b1, 1'b0, 32'h5,        2, 4'b0111};
    vecs[12] = '{1'b0, 32'h1004, 32'h0,        2'd1, 1'b1, 1'b0, 32'h00008000, 2, 4'b0011};

    // reset state
    #1;
    check("rst ready", {31'b0, req_ready}, 32'd1);
    check("rst resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst strobes", {30'b0, mem_memread, mem_memwrite}, 32'd0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst rdata/sm", {27'b0, resp_err, mem_sign_mask}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // back-to-back loads with req_valid held high
    begin
      logic [31:0] exp_r[3] = '{32'hABCD8000, 32'h5, 32'hCAFEF00D};
      logic [31:0] ad[3]    = '{32'h1004, 32'h2000, 32'h1008};
      int cyc = 0, k = 0, r = 0, last = -1, consec = 0;
      logic prev_s = 1'b0, s, acc;
      @(negedge clk);
      drive(1'b0, ad[0], 32'h0, 2'd2, 1'b1);
      req_valid = 1'b1;
      while (cyc < 40 && r < 3) begin
        if (cyc > 0) @(negedge clk);
        cyc++;
        s = mem_memread | mem_memwrite;
        if (prev_s && s) consec++;
        prev_s = s;
        if (resp_valid) begin
          check($sformatf("b2b rdata %0d", r), resp_rdata, exp_r[r]);
          r++;
        end
        acc = req_valid & req_ready;
        @(posedge clk);
        if (acc) begin
          if (last >= 0) check($sformatf("b2b spacing %0d", k), 32'(cyc - last), 32'd3);
          last = cyc;
          k++;
          #1;
          if (k < 3) drive(1'b0, ad[k], 32'h0, 2'd2, 1'b1);
          else       req_valid = 1'b0;
        end
      end
      check("b2b responses", 32'(r), 32'd3);
      check("b2b consecutive strobes", 32'(consec), 32'd0);
    end

    // reset during ISSUE of a store
    begin
      int seen = 0;
      repeat (2) @(negedge clk);
      drive(1'b1, 32'h1008, 32'h11111111, 2'd2, 1'b0);
      req_valid = 1'b1;
      @(posedge clk);
      #2;
      check("abort store strobe up", {31'b0, mem_memwrite}, 32'd1);
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("abort strobes", {30'b0, mem_memread, mem_memwrite}, 32'd0);
      check("abort ready", {31'b0, req_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (resp_valid) seen++;
      end
      check("abort no resp", 32'(seen), 32'd0);
      check("abort mem word", mem[2], 32'hCAFEF00D);
    end

    // RD_LATENCY=3 build
    begin
      int n = 0, lat = 0, strobes = 0;
      @(negedge clk);
      drive(1'b0, 32'h1004, 32'h0, 2'd2, 1'b0);
      req_valid3 = 1'b1;
      while (!req_ready3 && n < 20) begin @(negedge clk); n++; end
      @(posedge clk);
      #1 req_valid3 = 1'b0;
      @(negedge clk);
      while (!resp_valid3 && lat < 20) begin
        strobes += int'(mem_memread3) + int'(mem_memwrite3);
        @(negedge clk);
        lat++;
      end
      check("lat3 latency", 32'(lat), 32'd4);
      check("lat3 strobes", 32'(strobes), 32'd1);
      check("lat3 rdata", resp_rdata3, 32'h600DF00D);
      check("lat3 err", {31'b0, resp_err3}, 32'd0);
    end

    check("strobe overlap", 32'(overlap), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
